// File: rtl/stdp_pkg.sv
// Shared STDP case encoding for the column case classifier and its per-synapse trackers.
package stdp_pkg;

  localparam int CASE_CAPTURE = 0;
  localparam int CASE_MINUS   = 1;
  localparam int CASE_SEARCH  = 2;
  localparam int CASE_BACKOFF = 3;

  // Bits {backoff, search, minus, capture}; one-hot or all-zero.
  typedef logic [3:0] stdp_case_t;

endpackage

// File: rtl/stdp_case_array_tracker.sv
// Empty module kept for file layout; the per-synapse tracker lives in stdp_syn_tracker.sv.
module stdp_case_array_tracker_unused;
endmodule

// File: rtl/stdp_syn_tracker.sv
// One synapse: captures the first input spike time in the window and classifies it
// against the neuron output spike time.
module stdp_syn_tracker
  import stdp_pkg::*;
#(
  parameter int T_W     = 3,
  parameter int CAP_WIN = 7
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_grst,
  input  logic           i_win_en,
  input  logic           i_ein,
  input  logic [T_W-1:0] i_t_cnt,
  input  logic           i_oseen,
  input  logic [T_W-1:0] i_tout,
  output stdp_case_t     o_case,
  output logic [T_W-1:0] o_dt
);

  logic           r_seen;
  logic [T_W-1:0] r_tin;
  logic           w_in_first;
  logic [T_W-1:0] w_diff;

  // Input levels in the gamma cycle belong to no window and are dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_grst) begin
      r_seen <= 1'b0;
      r_tin  <= '0;
    end else if (i_ein && !r_seen) begin
      r_seen <= 1'b1;
      r_tin  <= i_t_cnt;
    end
  end

  assign w_in_first = (r_tin <= i_tout);
  assign w_diff     = w_in_first ? (i_tout - r_tin) : (r_tin - i_tout);

  always_comb begin
    o_case = '0;
    o_dt   = '0;
    if (r_seen && i_oseen) begin
      o_dt = w_diff;
      if (!w_in_first)
        o_case[CASE_MINUS] = 1'b1;
      else if (i_win_en && (int'(w_diff) > CAP_WIN))
        o_case[CASE_SEARCH] = 1'b1;
      else
        o_case[CASE_CAPTURE] = 1'b1;
    end else if (r_seen) begin
      o_case[CASE_SEARCH] = 1'b1;
    end else if (i_oseen) begin
      o_case[CASE_BACKOFF] = 1'b1;
    end
  end

endmodule

// File: rtl/stdp_case_array.sv
// Column STDP case classifier: shared unit-time counter, output spike tracker,
// N_SYN synapse trackers and the registered case/dt outputs.
module stdp_case_array
  import stdp_pkg::*;
#(
  parameter int N_SYN   = 16,
  parameter int T_W     = 3,
  parameter int CAP_WIN = 7
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      grst,
  input  logic                      win_en,
  input  logic [N_SYN-1:0]          ein,
  input  logic                      eout,
  output stdp_case_t [N_SYN-1:0]    stdp_cases,
  output logic [N_SYN-1:0][T_W-1:0] dt,
  output logic                      case_valid
);

  logic [T_W-1:0]            r_t_cnt;
  logic                      r_oseen;
  logic [T_W-1:0]            r_tout;
  stdp_case_t [N_SYN-1:0]    r_cases;
  logic [N_SYN-1:0][T_W-1:0] r_dt;
  logic                      r_case_valid;
  stdp_case_t [N_SYN-1:0]    w_cases;
  logic [N_SYN-1:0][T_W-1:0] w_dt;

  // Counter saturates so late spikes all share the maximum time.
  always_ff @(posedge clk) begin
    if (rst || grst)
      r_t_cnt <= '0;
    else if (r_t_cnt != {T_W{1'b1}})
      r_t_cnt <= r_t_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst || grst) begin
      r_oseen <= 1'b0;
      r_tout  <= '0;
    end else if (eout && !r_oseen) begin
      r_oseen <= 1'b1;
      r_tout  <= r_t_cnt;
    end
  end

  for (genvar g = 0; g < N_SYN; g++) begin : g_syn
    stdp_syn_tracker #(
      .T_W     (T_W),
      .CAP_WIN (CAP_WIN)
    ) u_trk (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_grst   (grst),
      .i_win_en (win_en),
      .i_ein    (ein[g]),
      .i_t_cnt  (r_t_cnt),
      .i_oseen  (r_oseen),
      .i_tout   (r_tout),
      .o_case   (w_cases[g]),
      .o_dt     (w_dt[g])
    );
  end

  // case_valid is a one-cycle strobe with no back-pressure: stdp_cases/dt are
  // new in the strobe cycle and hold until the next strobe or rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cases      <= '0;
      r_dt         <= '0;
      r_case_valid <= 1'b0;
    end else begin
      r_case_valid <= grst;
      if (grst) begin
        r_cases <= w_cases;
        r_dt    <= w_dt;
      end
    end
  end

  assign stdp_cases = r_cases;
  assign dt         = r_dt;
  assign case_valid = r_case_valid;

endmodule

// File: tb/tb_stdp_case_array.sv
// Directed bench for stdp_case_array: driver tasks push expected {cases, dt} into a
// queue; a negedge monitor pops and compares on every case_valid strobe.
module tb_stdp_case_array;

  localparam int N_SYN = 4;
  localparam int T_W   = 3;
  localparam int W     = N_SYN * (4 + T_W);

  localparam logic [3:0] NON = 4'b0000;
  localparam logic [3:0] CAP = 4'b0001;
  localparam logic [3:0] MIN = 4'b0010;
  localparam logic [3:0] SRC = 4'b0100;
  localparam logic [3:0] BCK = 4'b1000;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      grst;
  logic                      win_en;
  logic [N_SYN-1:0]          ein;
  logic                      eout;
  logic [N_SYN-1:0][3:0]     stdp_cases;
  logic [N_SYN-1:0][T_W-1:0] dt;
  logic                      case_valid;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  int           n_checks = 0;
  int           n_fail   = 0;

  stdp_case_array #(
    .N_SYN   (N_SYN),
    .T_W     (T_W),
    .CAP_WIN (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .grst       (grst),
    .win_en     (win_en),
    .ein        (ein),
    .eout       (eout),
    .stdp_cases (stdp_cases),
    .dt         (dt),
    .case_valid (case_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk(input logic [3:0] c3, input logic [3:0] c2,
                                      input logic [3:0] c1, input logic [3:0] c0,
                                      input logic [2:0] d3, input logic [2:0] d2,
                                      input logic [2:0] d1, input logic [2:0] d0);
    return {c3, c2, c1, c0, d3, d2, d1, d0};
  endfunction

  function automatic logic lvl(input int t, input int te, input logic pulse);
    return (te >= 0) && (t >= te) && !(pulse && (t > te));
  endfunction

  // driver: one window, t=0 is the first edge after the call; grst at t=tg
  task automatic run_window(input int te0, input int te1, input int te2, input int te3,
                            input int to, input int tg, input logic we,
                            input logic [3:0] pulse, input logic [W-1:0] expv);
    exp_q.push_back(expv);
    for (int t = 0; t <= tg; t++) begin
      ein[0] = lvl(t, te0, pulse[0]);
      ein[1] = lvl(t, te1, pulse[1]);
      ein[2] = lvl(t, te2, pulse[2]);
      ein[3] = lvl(t, te3, pulse[3]);
      eout   = lvl(t, to, 1'b0);
      grst   = (t == tg);
      win_en = we;
      @(posedge clk);
      #1;
    end
    grst   = 1'b0;
    win_en = 1'b0;
    ein    = '0;
    eout   = 1'b0;
    n_checks++;
    if (case_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: case_valid=%b required 1 in cycle after grst", case_valid);
    end
  endtask

  task automatic check_zero(input string name);
    n_checks++;
    if (case_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s case_valid: got %b required 0", name, case_valid);
    end
    n_checks++;
    if (stdp_cases !== '0) begin
      n_fail++;
      $display("FAIL %s stdp_cases: got %h required 0", name, stdp_cases);
    end
    n_checks++;
    if (dt !== '0) begin
      n_fail++;
      $display("FAIL %s dt: got %h required 0", name, dt);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (case_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected case_valid: got cases=%h dt=%h with nothing expected",
                 stdp_cases, dt);
      end else begin
        e = exp_q.pop_front();
        if ({stdp_cases, dt} !== e) begin
          n_fail++;
          $display("FAIL window result: got cases=%h dt=%h required cases=%h dt=%h",
                   stdp_cases, dt, e[W-1:N_SYN*T_W], e[N_SYN*T_W-1:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; grst = 1'b0; win_en = 1'b0; ein = '0; eout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // ordered spikes, ein[2] is a one-cycle level
    run_window(2, 6, 1, -1, 5, 7, 1'b0, 4'b0100, mk(BCK, CAP, MIN, CAP, 0, 4, 1, 3));
    // window check: diff 4 > 2 is search, diff 2 stays capture
    run_window(1, 3, -1, -1, 5, 7, 1'b1, 4'b0000, mk(BCK, BCK, CAP, SRC, 0, 0, 2, 4));
    run_window(1, 3, -1, -1, 5, 7, 1'b0, 4'b0000, mk(BCK, BCK, CAP, CAP, 0, 0, 2, 4));
    // no output spike
    run_window(0, -1, 0, -1, -1, 5, 1'b0, 4'b0000, mk(NON, SRC, NON, SRC, 0, 0, 0, 0));
    // saturation: both times clamp to 7
    run_window(9, -1, -1, -1, 12, 14, 1'b0, 4'b0000, mk(BCK, BCK, BCK, CAP, 0, 0, 0, 0));
    // same-cycle input and output spike
    run_window(-1, -1, 4, -1, 4, 6, 1'b0, 4'b0000, mk(BCK, CAP, BCK, BCK, 0, 0, 0, 0));

    // reset priority: partial window, rst, then rst with grst
    ein = 4'b1111; eout = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ein = '0; eout = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; ein = 4'b0011;
    repeat (2) @(posedge clk);
    #1;
    ein = '0; rst = 1'b1; grst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; grst = 1'b0;
    check_zero("rst_grst");
    // fresh window after reset, no leftover seen state on syn0/syn1
    run_window(-1, -1, -1, 2, 4, 6, 1'b0, 4'b0000, mk(CAP, BCK, BCK, BCK, 2, 0, 0, 0));

    // double gamma: full window then an empty one
    run_window(1, -1, -1, -1, 3, 5, 1'b0, 4'b0000, mk(BCK, BCK, BCK, CAP, 0, 0, 0, 2));
    run_window(-1, -1, -1, -1, -1, 0, 1'b0, 4'b0000, mk(NON, NON, NON, NON, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected results left, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
